// File: rtl/ternary_pkg.sv
// Shared types and helpers for the ternary-weight MAC array.
package ternary_pkg;

  localparam logic [1:0] W_ZERO    = 2'b00;
  localparam logic [1:0] W_POS     = 2'b01;
  localparam logic [1:0] W_NEG     = 2'b10;
  localparam logic [1:0] W_NEG_ALT = 2'b11;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Returns {zero, sign}: zero=1 means no contribution, sign=1 means subtract.
  function automatic logic [1:0] decode(input logic [1:0] w);
    logic zero;
    logic sign;
    zero = (w == W_ZERO);
    sign = (w == W_NEG) || (w == W_NEG_ALT);
    return {zero, sign};
  endfunction

endpackage

// File: rtl/ternary_mac_array_if.sv
// Input/stream bus of the ternary MAC array.
interface ternary_mac_array_if #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 2,
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 4
);
  logic                   in_valid;
  logic [2*ROWS-1:0]      in_weights;
  logic [COLS*IN_W-1:0]   in_act;
  logic                   in_signed;
  logic                   start_readout;
  logic [SHIFT_W-1:0]     cfg_shift;
  logic                   cfg_relu;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_last;

  modport master (
    output in_valid, in_weights, in_act, in_signed, start_readout,
           cfg_shift, cfg_relu, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_weights, in_act, in_signed, start_readout,
           cfg_shift, cfg_relu, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/ternary_mac_cell.sv
// One accumulator of the grid with its add/sub/hold selection.
module ternary_mac_cell
  import ternary_pkg::*;
#(
  parameter int unsigned ACC_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       weight,
  input  logic [ACC_W-1:0] act,
  output logic [ACC_W-1:0] acc_next
);
  logic [ACC_W-1:0] acc;
  logic [1:0]       dec;

  // Next accumulator value including this cycle's contribution (wraps).
  always_comb begin
    dec      = decode(weight);
    acc_next = acc;
    if (en && !dec[1]) begin
      acc_next = dec[0] ? (acc - act) : (acc + act);
    end
  end

  // Accumulator register; clear takes priority once the snapshot is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end
endmodule

// File: rtl/ternary_mac_array.sv
// ROWS x COLS ternary-weight MAC grid with double-buffered streamed readout.
module ternary_mac_array
  import ternary_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 2,
  parameter int unsigned IN_W    = 8,
  parameter int unsigned ACC_W   = 17,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  ternary_mac_array_if.slave bus
);
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [ACC_W-1:0]        act_ext [COLS];
  logic [ACC_W-1:0]        snap    [N];
  logic [ACC_W-1:0]        queue   [N];
  logic [IDX_W-1:0]        index;
  logic [SHIFT_W-1:0]      shift_q;
  logic                    relu_q;
  logic                    valid_q;
  state_t                  state;
  logic signed [ACC_W-1:0] sel;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] clamped;

  // Activation extension per column (zero or sign fill).
  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
      act_ext[c] = {{(ACC_W-IN_W){bus.in_signed & bus.in_act[c*IN_W + IN_W - 1]}},
                    bus.in_act[c*IN_W +: IN_W]};
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      ternary_mac_cell #(.ACC_W(ACC_W)) u_cell (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.in_valid),
        .clr      (bus.start_readout),
        .weight   (bus.in_weights[2*r +: 2]),
        .act      (act_ext[c]),
        .acc_next (snap[r*COLS + c])
      );
    end
  end

  // Snapshot buffer, loaded from the post-contribution accumulator values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < N; k++) queue[k] <= '0;
    end else if (bus.start_readout) begin
      for (int unsigned k = 0; k < N; k++) queue[k] <= snap[k];
    end
  end

  // Stream FSM: index, latched config and registered out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      index   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (bus.start_readout) begin
      state   <= STREAM;
      valid_q <= 1'b1;
      index   <= '0;
      shift_q <= bus.cfg_shift;
      relu_q  <= bus.cfg_relu;
    end else begin
      case (state)
        STREAM: begin
          if (bus.out_ready) begin
            if (index == LAST_IDX) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              index   <= '0;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Output post-processing: shift, optional ReLU, saturate; zero while idle.
  always_comb begin
    sel     = $signed(queue[index]);
    shifted = sel >>> shift_q;
    clamped = shifted;
    if (relu_q && shifted < 0) clamped = '0;
    if (clamped > SAT_MAX) clamped = SAT_MAX;
    else if (clamped < SAT_MIN) clamped = SAT_MIN;
    bus.out_data = valid_q ? clamped[OUT_W-1:0] : '0;
    bus.out_last = valid_q && (index == LAST_IDX);
  end

  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_ternary_mac_array.sv
// Self-checking bench for ternary_mac_array: directed cases plus random traffic.
module tb_ternary_mac_array;
  localparam int ROWS = 4, COLS = 2, IN_W = 8, ACC_W = 17, OUT_W = 8, SHIFT_W = 4;
  localparam int N = ROWS * COLS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ternary_mac_array_if #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .OUT_W(OUT_W),
                         .SHIFT_W(SHIFT_W)) bus ();

  ternary_mac_array #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .ACC_W(ACC_W),
                      .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int macc [ROWS][COLS];
  int mq   [N];
  bit mbusy;
  int midx;
  int mshift;
  bit mrelu;

  function automatic int wrap(input longint x);
    longint m;
    m = x & ((64'sd1 <<< ACC_W) - 1);
    if (m >= (64'sd1 <<< (ACC_W - 1))) m -= (64'sd1 <<< ACC_W);
    return int'(m);
  endfunction

  function automatic int wval(input logic [1:0] w);
    if (w == 2'b00) return 0;
    if (w == 2'b01) return 1;
    return -1;
  endfunction

  function automatic int proc(input int q, input int s, input bit relu);
    int v;
    v = q >>> s;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) macc[r][c] = 0;
    for (int k = 0; k < N; k++) mq[k] = 0;
    mbusy = 0; midx = 0; mshift = 0; mrelu = 0;
  endtask

  // One clock edge: advance the model with the driven inputs, then compare.
  task automatic tick();
    logic [7:0] a;
    int av;
    @(posedge clk);
    if (bus.in_valid) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          a = bus.in_act[c*IN_W +: IN_W];
          av = a;
          if (bus.in_signed && a[7]) av -= 256;
          macc[r][c] = wrap(longint'(macc[r][c]) + wval(bus.in_weights[2*r +: 2]) * av);
        end
    end
    if (bus.start_readout) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          mq[r*COLS + c] = macc[r][c];
          macc[r][c] = 0;
        end
      mshift = bus.cfg_shift; mrelu = bus.cfg_relu; midx = 0; mbusy = 1;
    end else if (mbusy && bus.out_ready) begin
      if (midx == N - 1) begin mbusy = 0; midx = 0; end
      else midx++;
    end
    #1;
    check("valid", int'(bus.out_valid), int'(mbusy));
    if (mbusy) begin
      check("data", int'($signed(bus.out_data)), proc(mq[midx], mshift, mrelu));
      check("last", int'(bus.out_last), int'(midx == N - 1));
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_weights = '0; bus.in_act = '0; bus.in_signed = 1;
    bus.start_readout = 0; bus.cfg_shift = '0; bus.cfg_relu = 0; bus.out_ready = 0;
  endtask

  task automatic drain();
    bus.out_ready = 1;
    for (int i = 0; i < N + 2; i++) if (mbusy) tick();
  endtask

  task automatic acc_n(input int n);
    bus.in_valid = 1;
    for (int i = 0; i < n; i++) tick();
    bus.in_valid = 0;
  endtask

  task automatic readout(input int s, input bit relu);
    bus.cfg_shift = SHIFT_W'(s); bus.cfg_relu = relu; bus.start_readout = 1;
    tick();
    bus.start_readout = 0;
  endtask

  int exp1 [N] = '{30, -9, -30, 9, 0, 0, 30, -9};
  int prev_data;
  bit prev_stall;

  initial begin
    idle_inputs();
    model_reset();
    #12;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_last", int'(bus.out_last), 0);
    @(negedge clk); reset = 0;

    // Signed accumulate, row-major stream
    bus.in_weights = 8'b01_00_10_01; bus.in_act = {8'hFD, 8'd10}; bus.in_signed = 1;
    acc_n(3);
    readout(0, 0);
    bus.out_ready = 1;
    for (int k = 0; k < N; k++) begin
      check("t1_data", int'($signed(bus.out_data)), exp1[k]);
      check("t1_last", int'(bus.out_last), int'(k == N - 1));
      tick();
    end
    check("t1_done", int'(bus.out_valid), 0);

    // Unsigned activation and saturation
    bus.out_ready = 0; bus.in_signed = 0; bus.in_weights = 8'h55; bus.in_act = {8'd0, 8'd200};
    acc_n(2);
    readout(0, 0);
    check("sat_hi", int'($signed(bus.out_data)), 127);
    acc_n(2);
    readout(2, 0);
    check("shift2", int'($signed(bus.out_data)), 100);
    drain();

    // ReLU, shift and negative saturation on -1000
    bus.in_signed = 1; bus.in_act = {8'd0, 8'h83};
    acc_n(8); readout(0, 1);
    check("relu", int'($signed(bus.out_data)), 0);
    acc_n(8); readout(4, 0);
    check("shift4", int'($signed(bus.out_data)), -63);
    acc_n(8); readout(0, 0);
    check("sat_lo", int'($signed(bus.out_data)), -128);
    drain();

    // Back-pressure: ready pattern 1,0,0,1,... with hold checks
    bus.in_weights = 8'($urandom); bus.in_act = 16'($urandom);
    acc_n(5);
    readout(1, 0);
    prev_stall = 0;
    for (int i = 0; i < 3 * N + 3 && mbusy; i++) begin
      if (prev_stall) check("stall_hold", int'($signed(bus.out_data)), prev_data);
      prev_data = int'($signed(bus.out_data));
      bus.out_ready = (i % 3 == 0);
      prev_stall = !bus.out_ready;
      tick();
    end
    check("bp_done", int'(mbusy), 0);

    // Overlap: accumulate during stream A, restart at index 3
    bus.in_weights = 8'($urandom); bus.in_act = 16'($urandom);
    acc_n(4);
    readout(0, 0);
    bus.out_ready = 1; bus.in_valid = 1;
    for (int i = 0; i < N && midx != 3; i++) begin
      bus.in_weights = 8'($urandom); bus.in_act = 16'($urandom);
      tick();
    end
    check("at_idx3", midx, 3);
    bus.start_readout = 1; tick(); bus.start_readout = 0;
    check("restart_idx0", midx, 0);
    acc_n(3);
    drain();
    readout(0, 0);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom); bus.in_weights = 8'($urandom);
      bus.in_act = 16'($urandom); bus.in_signed = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.start_readout = ($urandom_range(0, 11) == 0);
      bus.cfg_shift = 4'($urandom_range(0, 9)); bus.cfg_relu = 1'($urandom);
      tick();
    end
    idle_inputs();
    drain();

    // Async reset mid-stream at index 5
    bus.in_weights = 8'($urandom); bus.in_act = 16'($urandom); bus.in_signed = 1;
    acc_n(6);
    readout(0, 0);
    bus.out_ready = 1;
    for (int i = 0; i < N && midx != 5; i++) tick();
    check("at_idx5", midx, 5);
    #2 reset = 1;
    #1;
    check("async_valid", int'(bus.out_valid), 0);
    model_reset();
    @(negedge clk); reset = 0;
    bus.out_ready = 1;
    readout(0, 0);
    for (int k = 0; k < N; k++) begin
      check("post_rst_zero", int'($signed(bus.out_data)), 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ternary_mac_array.md
# ternary_mac_array

Parametrised ternary-weight (1.58-bit) multiply-accumulate array, next generation of the single-column 4-lane accumulator behind the top-level pins. A ROWS×COLS grid of accumulators is fed one ternary weight per row and one activation per column each cycle. On command, all accumulators are snapshotted into a double-buffered output queue and cleared. The queue is streamed out with a ready/valid handshake, with per-readout arithmetic shift, optional ReLU and saturation.

## Interface
- ROWS, 4, weight lanes (rows)
- COLS, 2, activation lanes (columns)
- IN_W, 8, activation width
- ACC_W, 17, accumulator width, ≥ IN_W+1
- OUT_W, 8, output width, ≤ ACC_W
- SHIFT_W, 4, width of the shift amount
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  accumulate this cycle's weights × activations
- in_weights  in  2·ROWS  row r uses bits [2r+1:2r]: 00 → 0, 01 → +1, 10 → −1, 11 → −1
- in_act  in  COLS·IN_W  column c uses bits [c·IN_W +: IN_W]
- in_signed  in  1  1: activations are two's complement; 0: activations are unsigned
- start_readout  in  1  snapshot accumulators into the queue, clear accumulators, (re)start the stream
- cfg_shift  in  SHIFT_W  arithmetic right shift applied on output, sampled at start_readout
- cfg_relu  in  1  clamp negative outputs to 0, sampled at start_readout
- out_valid  out  1  out_data holds a valid element
- out_ready  in  1  consumer accepts the element
- out_data  out  OUT_W  processed element, signed
- out_last  out  1  current element is the final one (index ROWS·COLS−1)

## Operation
- Activation extension: zero-extend to ACC_W when in_signed=0, sign-extend when in_signed=1.
- Per cell (r,c), when in_valid=1: acc += +act / −act / 0 according to the weight code. Accumulation is modulo 2^ACC_W and wraps; there is no accumulator saturation.
- start_readout at an edge:
  - queue[r][c] ← acc value including this edge's in_valid contribution.
  - acc ← 0.
  - cfg_shift and cfg_relu are latched.
  - Stream index ← 0, busy ← 1.
- Stream order is row-major: element k = r·COLS + c.
- Output processing per element, in this order:
  1. v = queue >>> shift (arithmetic).
  2. If relu and v<0, v = 0.
  3. Saturate to signed OUT_W: [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- States:
  - IDLE: out_valid=0.
  - STREAM: out_valid=1. The index advances on out_valid & out_ready. Acceptance at index ROWS·COLS−1 returns to IDLE.
- Accumulation continues during STREAM; the queue is independent of the accumulators (double buffering).
- start_readout during STREAM overwrites the queue, restarts at index 0 and relatches the config. An element handshaken on that same edge counts as consumed but is not replayed.
- in_valid=0 and start_readout=0: accumulators hold.

## Timing
- Reset values:
  - Accumulators, queue, index and latched config: 0.
  - State: IDLE.
  - out_valid=0, out_last=0, out_data=0.
- Accumulate latency is 1 cycle: the contribution is visible in acc after the edge.
- out_valid rises the cycle after start_readout is sampled; element 0 is presented then.
- out_data and out_last are combinational from registered queue, index and latched config only. There is no combinational path from any input to any output.
- Throughput is 1 element/cycle with out_ready held high. A full readout takes ROWS·COLS cycles.
- out_ready low: out_data, out_last and the index hold.
- Reset asserted mid-stream: immediate return to IDLE, out_valid=0 asynchronously; queue contents are lost.

## Structure
- Package ternary_pkg holds:
  - Weight code constants (W_ZERO=2'b00, W_POS=2'b01, W_NEG=2'b10, W_NEG_ALT=2'b11).
  - The state enum IDLE/STREAM.
  - A decode function returning {zero, sign}.
- Sub-module ternary_mac_cell, one accumulator plus its add/sub/hold mux. It is instantiated ROWS×COLS times via generate.
- Queue, index counter, FSM and output post-processing live in the top.

## Test plan
- Accumulate (defaults, signed): row weights {+1,−1,0,+1}, act {c0=10, c1=−3}, in_valid for 3 cycles, then start_readout, shift=0 → stream 30,−9,−30,9,0,0,30,−9 with out_last on element 7.
- Unsigned/saturate: in_signed=0, act c0=200, weight +1 for 2 cycles, shift=0 → element 0 = 127. With shift=2 → 100.
- ReLU/shift: acc −1000, cfg_relu=1 → 0. cfg_relu=0, shift=4 → −63. shift=0 → −128 (saturated).
- Back-pressure: toggle out_ready 1,0,0,1,… → each element appears exactly once in order, out_data stable while stalled.
- Double buffer and overlap: stream readout A while accumulating new data, then issue start_readout at index 3 → stream restarts at 0 with snapshot B, and the accumulators cleared exactly once.
- Async reset mid-stream at index 5 → out_valid=0 immediately. After release, start_readout yields all zeros.
